// File: rtl/pulse_qualifier.sv
// pulse_qualifier: per-channel high-pulse width measurement and window check.
// Each channel runs a DISARMED/IDLE/HIGH state machine and counts the cycles a
// line stays high. When the line falls, the channel fires a one-cycle strobe:
// `y` when the width is inside [min_width, max_width], otherwise `reject`.
// The channel also latches the measured width on `width_out`.
// Optional feature macro: PULSE_QUALIFIER_IRQ_EN adds sticky qualified-pulse
// flags (y_sticky), an interrupt (irq) and a clear input (irq_clr).
module pulse_qualifier #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef PULSE_QUALIFIER_IRQ_EN
  input  logic                      irq_clr,
  output logic                      irq,
  output logic [CHANNELS-1:0]       y_sticky,
`endif
  input  logic [CHANNELS-1:0]       x,
  input  logic [CNT_W-1:0]          min_width,
  input  logic [CNT_W-1:0]          max_width,
  output logic [CHANNELS-1:0]       y,
  output logic [CHANNELS-1:0]       reject,
  output logic [CHANNELS*CNT_W-1:0] width_out
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2
  } state_t;

  state_t           st  [CHANNELS];
  logic [CNT_W-1:0] cnt [CHANNELS];

  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] qual;

  // Saturating increment: a width counter parks at all-ones, never wraps
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Unsigned window test; an inverted window (lo > hi) accepts nothing
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // End-of-pulse detection and qualification against the live window inputs
  always_comb begin
    fall = '0;
    qual = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fall[i] = (st[i] == HIGH) && !x[i];
      qual[i] = in_window(cnt[i], min_width, max_width);
    end
  end

  // Per-channel state machine, width counter and registered strobes/width
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      reject    <= '0;
      width_out <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        st[i]  <= DISARMED;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        y[i]      <= fall[i] && qual[i];
        reject[i] <= fall[i] && !qual[i];
        case (st[i])
          DISARMED: begin
            // A line that is already high when reset is released is never measured
            if (!x[i]) st[i] <= IDLE;
          end
          IDLE: begin
            if (x[i]) begin
              cnt[i] <= CNT_W'(1);
              st[i]  <= HIGH;
            end
          end
          HIGH: begin
            if (x[i]) begin
              cnt[i] <= sat_inc(cnt[i]);
            end else begin
              width_out[i*CNT_W +: CNT_W] <= cnt[i];
              st[i]                       <= IDLE;
            end
          end
          default: st[i] <= DISARMED;
        endcase
      end
    end
  end

`ifdef PULSE_QUALIFIER_IRQ_EN
  // Sticky flags set together with y (set beats clear); irq is the OR one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      y_sticky <= '0;
      irq      <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (fall[i] && qual[i]) y_sticky[i] <= 1'b1;
        else if (irq_clr)       y_sticky[i] <= 1'b0;
      end
      irq <= |y_sticky;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_qualifier.sv
// tb_pulse_qualifier: directed-vector bench for pulse_qualifier (CHANNELS=4,
// CNT_W=4 so that saturation is reachable quickly). Inputs change 1 ns after a
// rising edge and outputs are checked at that same point, so each check sees
// the result of the edge that just sampled the inputs.
// Build with +define+PULSE_QUALIFIER_IRQ_EN to also exercise the interrupt flags.
module tb_pulse_qualifier;

  localparam int CH = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   x;
  logic [CW-1:0]   min_width;
  logic [CW-1:0]   max_width;
  logic [CH-1:0]   y;
  logic [CH-1:0]   reject;
  logic [CH*CW-1:0] width_out;
`ifdef PULSE_QUALIFIER_IRQ_EN
  logic            irq_clr;
  logic            irq;
  logic [CH-1:0]   y_sticky;
`endif

  int checks = 0;
  int errors = 0;

  pulse_qualifier #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PULSE_QUALIFIER_IRQ_EN
    .irq_clr   (irq_clr),
    .irq       (irq),
    .y_sticky  (y_sticky),
`endif
    .x         (x),
    .min_width (min_width),
    .max_width (max_width),
    .y         (y),
    .reject    (reject),
    .width_out (width_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] wfield(input int ch);
    return width_out[ch*CW +: CW];
  endfunction

  // High for w sampled edges on channel ch, then low; check the strobe cycle and the one after
  task automatic pulse(input string tag, input int ch, input int w,
                       input logic qualified, input int expw);
    logic [CH-1:0] m;
    m = '0;
    m[ch] = 1'b1;
    x[ch] = 1'b1;
    repeat (w) tick();
    chk({tag, "_nostrobe_while_high"}, {y, reject}, 0);
    x[ch] = 1'b0;
    tick();
    chk({tag, "_y"},      y,      qualified ? m : '0);
    chk({tag, "_reject"}, reject, qualified ? '0 : m);
    chk({tag, "_width"},  wfield(ch), expw);
    chk({tag, "_excl"},   y & reject, 0);
    tick();
    chk({tag, "_strobe_one_cycle"}, {y, reject}, 0);
  endtask

  initial begin
    rst       = 1'b1;
    x         = 4'b0001;
    min_width = 4'd1;
    max_width = 4'd15;
`ifdef PULSE_QUALIFIER_IRQ_EN
    irq_clr   = 1'b0;
`endif

    // Reset with ch0 held high through release
    tick();
    tick();
    chk("rst_y",      y,         0);
    chk("rst_reject", reject,    0);
    chk("rst_width",  width_out, 0);
`ifdef PULSE_QUALIFIER_IRQ_EN
    chk("rst_sticky", y_sticky,  0);
    chk("rst_irq",    irq,       0);
`endif
    rst = 1'b0;
    repeat (3) tick();
    chk("held_no_strobe_hi", {y, reject}, 0);
    x[0] = 1'b0;
    tick();
    chk("held_no_strobe_fall", {y, reject}, 0);
    chk("held_width", width_out, 0);
    pulse("ch0_w3", 0, 3, 1'b1, 3);

    // Window [2,5] on ch1
    min_width = 4'd2;
    max_width = 4'd5;
    pulse("ch1_w1", 1, 1, 1'b0, 1);
    pulse("ch1_w2", 1, 2, 1'b1, 2);
    pulse("ch1_w5", 1, 5, 1'b1, 5);
    pulse("ch1_w6", 1, 6, 1'b0, 6);
    chk("ch0_width_held", wfield(0), 3);

    // Saturation on ch2
    min_width = 4'd1;
    max_width = 4'd15;
    pulse("ch2_sat", 2, 20, 1'b1, 15);

    // Simultaneous ch0/ch3 pulses
    x = 4'b1001;
    repeat (4) tick();
    x = 4'b0000;
    tick();
    chk("sim_y",      y,         4'b1001);
    chk("sim_reject", reject,    0);
    chk("sim_w0",     wfield(0), 4);
    chk("sim_w3",     wfield(3), 4);

    // Pattern 1,0,1,1,0 on ch0
    x[0] = 1'b1; tick();
    chk("b2b_first_clear", y, 0);
    x[0] = 1'b0; tick();
    chk("b2b_y1",  y,         4'b0001);
    chk("b2b_w1",  wfield(0), 1);
    x[0] = 1'b1; tick();
    chk("b2b_gap", y, 0);
    x[0] = 1'b1; tick();
    x[0] = 1'b0; tick();
    chk("b2b_y2",  y,         4'b0001);
    chk("b2b_w2",  wfield(0), 2);
    tick();

    // Reset in the middle of a pulse
    x[0] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_strobe", {y, reject}, 0);
    chk("midrst_width",  width_out,   0);
    rst = 1'b0;
    tick();
    chk("midrst_held_hi", {y, reject}, 0);
    x[0] = 1'b0;
    tick();
    chk("midrst_rearm_no_strobe", {y, reject}, 0);
    pulse("midrst_w2", 0, 2, 1'b1, 2);

    // Inverted window rejects everything
    min_width = 4'd6;
    max_width = 4'd2;
    pulse("inv_w4", 3, 4, 1'b0, 4);

    // Window sampled at the falling edge only
    min_width = 4'd10;
    max_width = 4'd12;
    x[2] = 1'b1;
    repeat (3) tick();
    min_width = 4'd1;
    max_width = 4'd3;
    x[2] = 1'b0;
    tick();
    chk("late_win_y",     y,         4'b0100);
    chk("late_win_width", wfield(2), 3);
    tick();

`ifdef PULSE_QUALIFIER_IRQ_EN
    // Sticky flag and interrupt
    x[1] = 1'b1;
    repeat (2) tick();
    x[1] = 1'b0;
    tick();
    chk("irq_y",        y,        4'b0010);
    chk("irq_sticky",   y_sticky, 4'b0010);
    chk("irq_lag",      irq,      1'b0);
    tick();
    chk("irq_set",      irq,      1'b1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_clr_sticky", y_sticky, 0);
    tick();
    chk("irq_clr_irq",  irq,      1'b0);
    x[1] = 1'b1;
    repeat (2) tick();
    x[1] = 1'b0;
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_setwins_y",      y,        4'b0010);
    chk("irq_setwins_sticky", y_sticky, 4'b0010);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_qualifier.md
Name: pulse_qualifier

Overview:
- Multi-channel successor to the single-bit end-of-pulse detector.
- Per channel: measures the width of each high pulse on `x` in clock cycles and, on the falling edge, emits a one-cycle strobe.
  - Strobe goes on `y` if the width lies inside a programmable [min,max] window, otherwise on `reject`.
- Also reports the measured width.
- Sits between synchronised external inputs (buttons, sensor lines) and control FSMs needing debounced/qualified pulse events.

Parameters:
- CHANNELS, 4, number of independent input lines.
- CNT_W, 8, width-counter bits; count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- x  input  CHANNELS  pulse inputs, already synchronous to clk; bit i is channel i.
- min_width  input  CNT_W  minimum accepted pulse width (cycles), shared by all channels.
- max_width  input  CNT_W  maximum accepted pulse width (cycles), shared by all channels.
- y  output  CHANNELS  one-cycle strobe: qualified pulse ended on channel i.
- reject  output  CHANNELS  one-cycle strobe: pulse ended but width outside window.
- width_out  output  CHANNELS*CNT_W  last measured width, channel i at [i*CNT_W +: CNT_W].

Behaviour:
- Reset and sampling:
  - Fixed: one clock, `rst` synchronous active-high; all state updates on posedge `clk`.
  - Reset values: `y`=0, `reject`=0, `width_out`=0, all counters 0, every channel in DISARMED.
  - `x` is sampled at each rising edge; all outputs are registered.
- Per-channel FSM:
  - DISARMED: wait for `x`=0 sampled, then go to IDLE. A line already high at reset release is never measured.
  - IDLE: if `x`=1 sampled, set count=1 and go to HIGH.
  - HIGH, `x`=1 sampled: count = count+1, saturating at 2^CNT_W-1 (no wrap).
  - HIGH, `x`=0 sampled: go to IDLE. In the same edge, register width_out[i]=count and evaluate qualification. The strobe is visible for exactly the one following cycle.
- Latency: `y`/`reject` assert in the cycle after the first edge where `x` is sampled 0 following a high run; then deassert.
  - Example: x high for 3 edges → `y` high during the next cycle only, `width_out`=3.
- Qualification:
  - Qualified iff min_width <= count <= max_width, unsigned compare.
  - Qualified → `y[i]`=1; otherwise → `reject[i]`=1. Never both in the same cycle.
  - If min_width > max_width, every pulse is rejected.
  - `min_width`/`max_width` are sampled only at the falling-edge evaluation; changing them mid-pulse is legal.
- Saturation: a pulse longer than 2^CNT_W-1 cycles reports width 2^CNT_W-1 and qualifies against that value.
- Back-to-back pulses:
  - Pattern 1,0,1 (single low cycle): the second pulse starts counting from the IDLE transition edge. Falling evaluation and new rising edge never coincide, since a 0 sample is required between them.
- Channel independence: channels are fully independent; simultaneous strobes on several channels are allowed.
- Reset mid-pulse:
  - Any in-progress count is discarded with no strobe.
  - `width_out` clears.
  - Channel returns to DISARMED and requires a low sample before rearming.
- `width_out` holds its value until the next pulse end on that channel.

Optional Feature:
- Macro `PULSE_QUALIFIER_IRQ_EN`.
- When defined, adds ports:
  - `irq_clr` input 1.
  - `irq` output 1, reset 0.
  - `y_sticky` output CHANNELS, reset 0.
- Sticky behaviour:
  - `y_sticky[i]` sets on the cycle `y[i]` asserts and clears when `irq_clr`=1.
  - Set wins over a simultaneous clear.
  - `irq` = registered OR of `y_sticky`.
- When not defined: none of these ports or registers exist; the interface is exactly as listed above.

Test Plan:
- Reset with x[0]=1 held through reset release, then x[0]=0, then 3-cycle high pulse:
  - No strobe for the held pulse.
  - Then `y[0]`=1 for one cycle and `width_out[0]`=3.
  - All outputs 0 during reset.
- min=2, max=5, pulses of widths 1, 2, 5, 6 on ch1:
  - Widths 1 and 6: `reject[1]` strobes.
  - Widths 2 and 5: `y[1]` strobes.
  - `width_out[1]` tracks 1, 2, 5, 6.
  - `y` and `reject` are never both high.
- CNT_W=4, min=1, max=15, 20-cycle pulse on ch2:
  - `width_out[2]`=15 (saturated), `y[2]` strobes once.
- Simultaneous 4-cycle pulses on ch0 and ch3, then a 1,0,1,1,0 pattern on ch0:
  - Both channels strobe in the same cycle.
  - ch0 then reports widths 1 and 2 in successive strobes.
- `rst` asserted after 3 high cycles of a pulse:
  - No strobe and `width_out`=0.
  - A following low then 2-cycle pulse gives `width_out`=2.
- With `PULSE_QUALIFIER_IRQ_EN`, qualified pulse on ch1:
  - `y_sticky[1]`=1 and `irq`=1 one cycle later.
  - `irq_clr` pulse clears both.
  - `irq_clr` coincident with a new `y[1]` leaves `y_sticky[1]`=1.
